// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths, grant encoding and starvation FSM states for the
// register-file writeback scheduler.
package rf_wb_scheduler_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_MDU  = 2'd2
   } gnt_e;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } starve_state_e;

endpackage

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Busy scoreboard for pending MDU destinations, outstanding-op counter,
// decode hazard detection and the protocol error terms tied to them.
module rf_scoreboard
   import rf_wb_scheduler_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic                  id_rd_wr_i,
   input  logic                  id_mdu_issue_i,
   input  logic                  accept_i,
   input  logic [REG_ADDR_W-1:0] acc_rd_i,
   input  logic                  pipe_gnt_i,
   input  logic [REG_ADDR_W-1:0] pipe_rd_i,
   output logic                  stall_id_o,
   output logic                  err_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [3:0]          out_cnt_q, out_cnt_d;
   logic                stall_raw;
   logic                issue;
   logic                cnt_full;

   assign cnt_full  = (out_cnt_q >= 4'(MAX_OUTSTANDING));

   // Hazard against any pending MDU destination, or no room for another op.
   assign stall_raw = (id_use_rs1_i && busy_q[id_rs1_i]) ||
                      (id_use_rs2_i && busy_q[id_rs2_i]) ||
                      (id_rd_wr_i   && busy_q[id_rd_i])  ||
                      (id_mdu_issue_i && cnt_full);

   // Decode is never frozen while the scheduler itself is in reset.
   assign stall_id_o = stall_raw && !rst;
   assign issue      = id_mdu_issue_i && !stall_raw && !rst;

   // Busy/count next state; a same-cycle set beats the clear on collision.
   always_comb begin
      busy_d    = busy_q;
      out_cnt_d = out_cnt_q;
      if (accept_i)
         busy_d[acc_rd_i] = 1'b0;
      if (issue && (id_rd_i != '0))
         busy_d[id_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
      if (issue && !accept_i)
         out_cnt_d = out_cnt_q + 4'd1;
      else if (accept_i && !issue && (out_cnt_q != 4'd0))
         out_cnt_d = out_cnt_q - 4'd1;
   end

   // Error terms: each is a single-cycle pulse folded into the sticky flag upstream.
   always_comb begin
      err_o = 1'b0;
      if (pipe_gnt_i && busy_q[pipe_rd_i])
         err_o = 1'b1;
      if (accept_i && (acc_rd_i != '0) && !busy_q[acc_rd_i])
         err_o = 1'b1;
      if (accept_i && (out_cnt_q == 4'd0))
         err_o = 1'b1;
      if (issue && !accept_i && cnt_full)
         err_o = 1'b1;
      if (issue && accept_i && (id_rd_i != '0) && (id_rd_i == acc_rd_i))
         err_o = 1'b1;
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= '0;
         out_cnt_q <= '0;
      end else begin
         busy_q    <= busy_d;
         out_cnt_q <= out_cnt_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write port scheduler: arbitrates WE3/A3/WD3 between the
// writeback stage and the MDU, with an anti-starvation force mode.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_NORMAL | pipe has priority; count consecutive refused MDU cycles
// ST_FORCE  | MDU wins the next cycle it is valid; pipe is held meanwhile
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int STARVE_LIMIT    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  id_rd_wr,
   input  logic                  id_mdu_issue,
   output logic                  stall_id,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  wb_hold,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]       mdu_data,
   output logic                  mdu_ready,
   output logic                  rf_we3,
   output logic [REG_ADDR_W-1:0] rf_a3,
   output logic [XLEN-1:0]       rf_wd3,
   output logic                  sb_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   starve_state_e state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          sb_err_q, sb_err_d;
   gnt_e          gnt;
   logic          pipe_req, mdu_req;
   logic          sb_err_term;
   logic [SW-1:0] starve_inc;

   assign pipe_req   = wb_we && (wb_rd != '0);
   assign mdu_req    = mdu_valid;
   assign starve_inc = starve_q + 1'b1;

   // One grant per cycle; force mode overrides pipe priority.
   always_comb begin
      gnt       = GNT_NONE;
      mdu_ready = 1'b0;
      wb_hold   = 1'b0;
      if (!rst) begin
         if ((state_q == ST_FORCE) && mdu_req) begin
            gnt       = GNT_MDU;
            mdu_ready = 1'b1;
            wb_hold   = pipe_req;
         end else if (pipe_req) begin
            gnt = GNT_PIPE;
         end else begin
            mdu_ready = 1'b1;
            if (mdu_req)
               gnt = GNT_MDU;
         end
      end
   end

   // Write port mux; an MDU result for x0 is consumed but never written.
   always_comb begin
      rf_we3 = 1'b0;
      rf_a3  = '0;
      rf_wd3 = '0;
      case (gnt)
         GNT_PIPE: begin
            rf_we3 = 1'b1;
            rf_a3  = wb_rd;
            rf_wd3 = wb_data;
         end
         GNT_MDU: begin
            rf_we3 = (mdu_rd != '0);
            rf_a3  = mdu_rd;
            rf_wd3 = mdu_data;
         end
         default: ;
      endcase
   end

   // Starvation FSM next state.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         ST_NORMAL: begin
            if (mdu_req && (gnt == GNT_PIPE)) begin
               if (starve_inc == SW'(STARVE_LIMIT)) begin
                  state_d  = ST_FORCE;
                  starve_d = '0;
               end else begin
                  starve_d = starve_inc;
               end
            end else begin
               starve_d = '0;
            end
         end
         ST_FORCE: begin
            starve_d = '0;
            if (gnt == GNT_MDU)
               state_d = ST_NORMAL;
         end
         default: begin
            state_d  = ST_NORMAL;
            starve_d = '0;
         end
      endcase
   end

   assign sb_err_d = sb_err_q || sb_err_term;

   // FSM, starvation counter and sticky error register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_NORMAL;
         starve_q <= '0;
         sb_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         sb_err_q <= sb_err_d;
      end
   end

   assign sb_err = sb_err_q;

   rf_scoreboard #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_scoreboard (
      .clk            (clk),
      .rst            (rst),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_rd_i        (id_rd),
      .id_use_rs1_i   (id_use_rs1),
      .id_use_rs2_i   (id_use_rs2),
      .id_rd_wr_i     (id_rd_wr),
      .id_mdu_issue_i (id_mdu_issue),
      .accept_i       (mdu_ready && mdu_valid),
      .acc_rd_i       (mdu_rd),
      .pipe_gnt_i     (gnt == GNT_PIPE),
      .pipe_rd_i      (wb_rd),
      .stall_id_o     (stall_id),
      .err_o          (sb_err_term)
   );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_rd_wr, id_mdu_issue;
   logic        stall_id;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_hold;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we3;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic        sb_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_wr(id_rd_wr),
      .id_mdu_issue(id_mdu_issue), .stall_id(stall_id),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .sb_err(sb_err)
   );

   // advance one clock, then let registered state settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_rd_wr = 0; id_mdu_issue = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
   endtask

   task automatic issue_mdu(input logic [4:0] rd);
      id_mdu_issue = 1; id_rd = rd;
      tick();
      id_mdu_issue = 0; id_rd = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick(); tick();
      mdu_valid = 1; mdu_rd = 5; wb_we = 1; wb_rd = 3;
      id_use_rs1 = 1; id_rs1 = 5;
      #1;
      checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b exp=0", rf_we3); end
      checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL reset_mdu_ready got=%b exp=0", mdu_ready); end
      checks++; if (wb_hold !== 1'b0) begin failures++; $display("FAIL reset_wb_hold got=%b exp=0", wb_hold); end
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
      tick();
      clear_inputs();
      rst = 0;
      #1;
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
   endtask

   task automatic test_mdu_write();
      id_rd_wr = 1;
      issue_mdu(5'd5);
      id_rd_wr = 0;
      id_use_rs1 = 1; id_rs1 = 5;
      mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h12345678;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL mdu_wr_ready got=%b exp=1", mdu_ready); end
      checks++; if (rf_we3 !== 1'b1) begin failures++; $display("FAIL mdu_wr_we3 got=%b exp=1", rf_we3); end
      checks++; if (rf_a3 !== 5'd5) begin failures++; $display("FAIL mdu_wr_a3 got=%0d exp=5", rf_a3); end
      checks++; if (rf_wd3 !== 32'h12345678) begin failures++; $display("FAIL mdu_wr_wd3 got=%h exp=12345678", rf_wd3); end
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL mdu_wr_stall_same got=%b exp=1", stall_id); end
      tick();
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
      #1;
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL mdu_wr_busy_clear got=%b exp=0", stall_id); end
      clear_inputs();
   endtask

   task automatic test_raw_stall();
      issue_mdu(5'd7);
      id_use_rs1 = 1; id_rs1 = 7;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL raw_stall_wait%0d got=%b exp=1", i, stall_id); end
         tick();
      end
      mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hCAFE0007;
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL raw_stall_wrcycle got=%b exp=1", stall_id); end
      tick();
      mdu_valid = 0;
      #1;
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL raw_stall_release got=%b exp=0", stall_id); end
      clear_inputs();
   endtask

   task automatic test_pipe_priority();
      wb_we = 1; wb_rd = 3; wb_data = 32'hA5A5_0003;
      mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h1111_1111;
      #1;
      checks++; if (rf_a3 !== 5'd3) begin failures++; $display("FAIL prio_a3 got=%0d exp=3", rf_a3); end
      checks++; if (rf_wd3 !== 32'hA5A5_0003) begin failures++; $display("FAIL prio_wd3 got=%h exp=a5a50003", rf_wd3); end
      checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL prio_mdu_ready got=%b exp=0", mdu_ready); end
      checks++; if (wb_hold !== 1'b0) begin failures++; $display("FAIL prio_wb_hold got=%b exp=0", wb_hold); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_starvation();
      issue_mdu(5'd9);
      wb_we = 1; wb_rd = 3; wb_data = 32'hD00D_0001;
      mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h9999_0009;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (mdu_ready !== 1'b0 || rf_a3 !== 5'd3 || wb_hold !== 1'b0)
            begin failures++; $display("FAIL starve_refuse%0d ready=%b a3=%0d hold=%b exp ready=0 a3=3 hold=0", i, mdu_ready, rf_a3, wb_hold); end
         tick();
      end
      #1;
      checks++; if (wb_hold !== 1'b1) begin failures++; $display("FAIL starve_force_hold got=%b exp=1", wb_hold); end
      checks++; if (mdu_ready !== 1'b1 || rf_a3 !== 5'd9 || rf_wd3 !== 32'h9999_0009)
         begin failures++; $display("FAIL starve_force_gnt ready=%b a3=%0d wd3=%h exp ready=1 a3=9 wd3=99990009", mdu_ready, rf_a3, rf_wd3); end
      tick();
      mdu_valid = 0;
      #1;
      checks++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd3 || rf_wd3 !== 32'hD00D_0001 || wb_hold !== 1'b0)
         begin failures++; $display("FAIL starve_held_pipe we=%b a3=%0d wd3=%h hold=%b exp we=1 a3=3 wd3=d00d0001 hold=0", rf_we3, rf_a3, rf_wd3, wb_hold); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_x0_and_outstanding();
      wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
      #1;
      checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL x0_pipe_we3 got=%b exp=0", rf_we3); end
      tick();
      clear_inputs();
      issue_mdu(5'd0);
      mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h0BAD_0000;
      #1;
      checks++; if (mdu_ready !== 1'b1 || rf_we3 !== 1'b0)
         begin failures++; $display("FAIL x0_mdu ready=%b we=%b exp ready=1 we=0", mdu_ready, rf_we3); end
      tick();
      clear_inputs();
      for (int r = 10; r < 14; r++) issue_mdu(5'(r));
      id_mdu_issue = 1; id_rd = 14;
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL max_out_stall got=%b exp=1", stall_id); end
      mdu_valid = 1; mdu_rd = 10;
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL max_out_accept_cycle got=%b exp=1", stall_id); end
      tick();
      mdu_valid = 0;
      #1;
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL max_out_release got=%b exp=0", stall_id); end
      tick();
      id_mdu_issue = 0; id_rd = 0;
      for (int r = 11; r < 15; r++) begin
         mdu_valid = 1; mdu_rd = 5'(r);
         tick();
      end
      clear_inputs();
      #1;
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL clean_sb_err got=%b exp=0", sb_err); end
   endtask

   task automatic test_error();
      mdu_valid = 1; mdu_rd = 20; mdu_data = 32'h0000_0020;
      #1;
      checks++; if (mdu_ready !== 1'b1 || rf_we3 !== 1'b1)
         begin failures++; $display("FAIL spurious_accept ready=%b we=%b exp ready=1 we=1", mdu_ready, rf_we3); end
      tick();
      clear_inputs();
      #1;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL sb_err_set got=%b exp=1", sb_err); end
      tick(); tick(); tick();
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL sb_err_sticky got=%b exp=1", sb_err); end
   endtask

   task automatic test_reset_mid_stall();
      issue_mdu(5'd8);
      id_use_rs1 = 1; id_rs1 = 8;
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", stall_id); end
      rst = 1;
      #1;
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL midrst_during got=%b exp=0", stall_id); end
      tick();
      rst = 0;
      #1;
      checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL midrst_busy_cleared got=%b exp=0", stall_id); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL midrst_sb_err got=%b exp=0", sb_err); end
      clear_inputs();
      mdu_valid = 1; mdu_rd = 8; mdu_data = 32'h0000_0008;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL late_result_ready got=%b exp=1", mdu_ready); end
      tick();
      clear_inputs();
      #1;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL late_result_err got=%b exp=1", sb_err); end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_mdu_write();
      test_raw_stall();
      test_pipe_priority();
      test_starvation();
      test_x0_and_outstanding();
      test_error();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
